// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS main controller: registered-state FSM sequencing fetch/decode/execute/memory/write-back,
// with memory-ready handshake, stall timeout into a sticky bus error, illegal-op pulse and retired count.
module multicycle_controller #(
   parameter int MEM_TIMEOUT = 255,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [5:0]       opcode,
   input  logic [5:0]       func,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             pc_en,
   output logic [1:0]       pc_src,
   output logic             i_or_d,
   output logic             mem_read,
   output logic             mem_write,
   output logic             ir_write,
   output logic             reg_dst,
   output logic             jal_reg,
   output logic             pc_to_reg,
   output logic             mem_to_reg,
   output logic             reg_write,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [2:0]       alu_operation,
   output logic             illegal_instr,
   output logic             bus_error,
   output logic [3:0]       state_out,
   output logic [CNT_W-1:0] instr_count
);
   localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

   typedef enum logic [3:0] {
      S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_MEM_ADDR = 4'd3,
      S_MEM_RD = 4'd4, S_MEM_WB = 4'd5, S_MEM_WR = 4'd6, S_R_EX = 4'd7,
      S_R_WB = 4'd8, S_I_EX = 4'd9, S_I_WB = 4'd10, S_BRANCH = 4'd11,
      S_JUMP = 4'd12, S_JAL = 4'd13, S_JR = 4'd14, S_ERROR = 4'd15
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000, OP_LW  = 6'b100011, OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100, OP_BNE = 6'b000101, OP_J    = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011, OP_ADDI = 6'b001000, OP_ANDI = 6'b001100;
   localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100;
   localparam logic [5:0] F_OR  = 6'b100101, F_SLT = 6'b101010, F_JR  = 6'b001000;
   localparam logic [2:0] ALU_AND = 3'b000, ALU_OR = 3'b001, ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110, ALU_SLT = 3'b111;

   state_t             state_q, state_d;
   logic [WAIT_W-1:0]  wait_q, wait_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               r_legal, timeout;
   logic [2:0]         r_op, i_op;

   always_comb begin
      r_legal = 1'b1;
      r_op    = ALU_ADD;
      case (func)
         F_ADD:   r_op = ALU_ADD;
         F_SUB:   r_op = ALU_SUB;
         F_AND:   r_op = ALU_AND;
         F_OR:    r_op = ALU_OR;
         F_SLT:   r_op = ALU_SLT;
         default: r_legal = 1'b0;
      endcase
   end

   assign i_op    = (opcode == OP_ANDI) ? ALU_AND : ALU_ADD;
   // Only meaningful in the three memory-wait states; callers gate on mem_ready too.
   assign timeout = (MEM_TIMEOUT != 0) && !mem_ready && (wait_q == WAIT_W'(MEM_TIMEOUT));

   always_comb begin
      state_d       = state_q;
      pc_en         = 1'b0;
      pc_src        = 2'b00;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_dst       = 1'b0;
      jal_reg       = 1'b0;
      pc_to_reg     = 1'b0;
      mem_to_reg    = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_operation = 3'b000;
      illegal_instr = 1'b0;
      bus_error     = 1'b0;
      case (state_q)
         S_IDLE: state_d = S_FETCH;
         S_FETCH: begin
            mem_read      = 1'b1;
            alu_src_b     = 2'b01;
            alu_operation = ALU_ADD;
            if (mem_ready) begin
               ir_write = 1'b1;
               pc_en    = 1'b1;
               state_d  = S_DECODE;
            end else if (timeout) begin
               state_d = S_ERROR;
            end
         end
         S_DECODE: begin
            alu_src_b     = 2'b11;
            alu_operation = ALU_ADD;
            case (opcode)
               OP_RTYPE: begin
                  if (func == F_JR) state_d = S_JR;
                  else if (r_legal) state_d = S_R_EX;
                  else begin
                     illegal_instr = 1'b1;
                     state_d       = S_FETCH;
                  end
               end
               OP_LW, OP_SW:    state_d = S_MEM_ADDR;
               OP_BEQ, OP_BNE:  state_d = S_BRANCH;
               OP_J:            state_d = S_JUMP;
               OP_JAL:          state_d = S_JAL;
               OP_ADDI, OP_ANDI: state_d = S_I_EX;
               default: begin
                  illegal_instr = 1'b1;
                  state_d       = S_FETCH;
               end
            endcase
         end
         S_MEM_ADDR: begin
            alu_src_a     = 1'b1;
            alu_src_b     = 2'b10;
            alu_operation = ALU_ADD;
            state_d       = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
         end
         S_MEM_RD: begin
            i_or_d   = 1'b1;
            mem_read = 1'b1;
            if (mem_ready) state_d = S_MEM_WB;
            else if (timeout) state_d = S_ERROR;
         end
         S_MEM_WB: begin
            mem_to_reg = 1'b1;
            reg_write  = 1'b1;
            state_d    = S_FETCH;
         end
         S_MEM_WR: begin
            i_or_d    = 1'b1;
            mem_write = 1'b1;
            if (mem_ready) state_d = S_FETCH;
            else if (timeout) state_d = S_ERROR;
         end
         S_R_EX: begin
            alu_src_a     = 1'b1;
            alu_operation = r_op;
            state_d       = S_R_WB;
         end
         S_R_WB: begin
            reg_dst       = 1'b1;
            reg_write     = 1'b1;
            alu_operation = r_op;
            state_d       = S_FETCH;
         end
         S_I_EX: begin
            alu_src_a     = 1'b1;
            alu_src_b     = 2'b10;
            alu_operation = i_op;
            state_d       = S_I_WB;
         end
         S_I_WB: begin
            reg_write     = 1'b1;
            alu_operation = i_op;
            state_d       = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a     = 1'b1;
            alu_operation = ALU_SUB;
            pc_src        = 2'b01;
            pc_en         = (opcode == OP_BNE) ? ~zero : zero;
            state_d       = S_FETCH;
         end
         S_JUMP: begin
            pc_src  = 2'b10;
            pc_en   = 1'b1;
            state_d = S_FETCH;
         end
         S_JAL: begin
            pc_src    = 2'b10;
            pc_en     = 1'b1;
            jal_reg   = 1'b1;
            pc_to_reg = 1'b1;
            reg_write = 1'b1;
            state_d   = S_FETCH;
         end
         S_JR: begin
            pc_src  = 2'b11;
            pc_en   = 1'b1;
            state_d = S_FETCH;
         end
         default: bus_error = 1'b1;
      endcase
   end

   // Stall counter restarts whenever a wait state is freshly entered.
   always_comb begin
      wait_d = wait_q;
      if (state_d != state_q) wait_d = '0;
      else if ((state_q == S_FETCH || state_q == S_MEM_RD || state_q == S_MEM_WR) && !mem_ready)
         wait_d = wait_q + WAIT_W'(1);
   end

   always_comb begin
      count_d = count_q;
      if (state_q inside {S_MEM_WB, S_MEM_WR, S_R_WB, S_I_WB, S_BRANCH, S_JUMP, S_JAL, S_JR}
          && state_d == S_FETCH)
         count_d = count_q + CNT_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         wait_q  <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         count_q <= count_d;
      end
   end

   assign state_out   = state_q;
   assign instr_count = count_q;
endmodule
